// File: rtl/pc_fetch_unit_if.sv
// Fetch-side bus bundle: instruction-memory request/ack channel plus the
// valid/ready channel that hands fetched instructions to decode.
interface pc_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pc4;

  modport master (
    output imem_req, imem_addr, if_valid, if_instr, if_pc, if_pc4,
    input  imem_ack, imem_rdata, if_ready
  );

  modport slave (
    input  imem_req, imem_addr, if_valid, if_instr, if_pc, if_pc4,
    output imem_ack, imem_rdata, if_ready
  );
endinterface

// File: rtl/pc_fetch_unit.sv
// PC register and fetch sequencer with branch/jump redirect and in-flight kill.
// Optional macro MISALIGN_TRAP_EN: misaligned redirect targets go to TRAP_VECTOR.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000
`ifdef MISALIGN_TRAP_EN
  , parameter logic [31:0] TRAP_VECTOR = 32'h0000_0080
`endif
) (
  input  logic                   clk,
  input  logic                   rst_n,
  pc_fetch_unit_if.master        bus,
  input  logic                   br_taken,
  input  logic [31:0]            br_base,
  input  logic [31:0]            br_offset,
  input  logic                   jmp_taken,
  input  logic [31:0]            jmp_target
`ifdef MISALIGN_TRAP_EN
  , output logic                 misalign_err
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    VALID = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] ipc_q, ipc_d;
  logic [31:0] ipc4_q, ipc4_d;
  logic        req_q, req_d;
  logic        valid_q, valid_d;
  logic        kill_q, kill_d;

  logic        redirect;
  logic [31:0] target;
  logic [31:0] load_pc;
  logic [31:0] pc_plus4;

`ifdef MISALIGN_TRAP_EN
  logic misalign_q, misalign_d;
`endif

  // Jump wins over branch; alignment is judged on the already-selected target.
  always_comb begin
    redirect = jmp_taken | br_taken;
    target   = jmp_taken ? jmp_target : (br_base + br_offset);
    pc_plus4 = pc_q + 32'd4;
`ifdef MISALIGN_TRAP_EN
    misalign_d = redirect && (target[1:0] != 2'b00);
    load_pc    = misalign_d ? TRAP_VECTOR : target;
`else
    load_pc    = target;
`endif
  end

  always_comb begin
    // NOTE: every *_d starts as its *_q so no path through the case leaves a
    // variable unassigned, which would otherwise infer a latch.
    state_d = state_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    instr_d = instr_q;
    ipc_d   = ipc_q;
    ipc4_d  = ipc4_q;
    req_d   = req_q;
    valid_d = valid_q;
    kill_d  = kill_q;

    case (state_q)
      IDLE: begin
        state_d = FETCH;
        req_d   = 1'b1;
        pc_d    = redirect ? load_pc : pc_q;
        addr_d  = redirect ? load_pc : pc_q;
      end
      FETCH: begin
        if (bus.imem_ack) begin
          kill_d = 1'b0;
          if (redirect) begin
            pc_d   = load_pc;
            addr_d = load_pc;
          end else if (kill_q) begin
            addr_d = pc_q;
          end else begin
            instr_d = bus.imem_rdata;
            ipc_d   = pc_q;
            ipc4_d  = pc_plus4;
            pc_d    = pc_plus4;
            valid_d = 1'b1;
            req_d   = 1'b0;
            state_d = VALID;
          end
        end else if (redirect) begin
          // Request address stays put until ack; the stale word is dropped.
          pc_d   = load_pc;
          kill_d = 1'b1;
        end
      end
      VALID: begin
        if (redirect) begin
          valid_d = 1'b0;
          pc_d    = load_pc;
          addr_d  = load_pc;
          req_d   = 1'b1;
          state_d = FETCH;
        end else if (bus.if_ready) begin
          valid_d = 1'b0;
          addr_d  = pc_q;
          req_d   = 1'b1;
          state_d = FETCH;
        end
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
        valid_d = 1'b0;
      end
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      addr_q  <= RESET_PC;
      instr_q <= '0;
      ipc_q   <= '0;
      ipc4_q  <= '0;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
      kill_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
      ipc4_q  <= ipc4_d;
      req_q   <= req_d;
      valid_q <= valid_d;
      kill_q  <= kill_d;
    end
  end

`ifdef MISALIGN_TRAP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) misalign_q <= 1'b0;
    else        misalign_q <= misalign_d;
  end
  assign misalign_err = misalign_q;
`endif

  assign bus.imem_req  = req_q;
  assign bus.imem_addr = addr_q;
  assign bus.if_valid  = valid_q;
  assign bus.if_instr  = instr_q;
  assign bus.if_pc     = ipc_q;
  assign bus.if_pc4    = ipc4_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboard bench for pc_fetch_unit: expected fetch addresses and accepted
// instructions are queued by the stimulus and checked by negedge monitors.
module tb_pc_fetch_unit;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } acc_t;

  logic        clk;
  logic        rst_n;
  logic        br_taken;
  logic [31:0] br_base;
  logic [31:0] br_offset;
  logic        jmp_taken;
  logic [31:0] jmp_target;
`ifdef MISALIGN_TRAP_EN
  logic        misalign_err;
`endif

  pc_fetch_unit_if bus ();

  pc_fetch_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .br_taken   (br_taken),
    .br_base    (br_base),
    .br_offset  (br_offset),
    .jmp_taken  (jmp_taken),
    .jmp_target (jmp_target)
`ifdef MISALIGN_TRAP_EN
    , .misalign_err (misalign_err)
`endif
  );

  int          n_cmp = 0;
  int          n_err = 0;
  int          lat   = 1;
  logic [31:0] exp_req[$];
  acc_t        exp_acc[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == 32'h0000_0004) ? 32'h8C22_0004 : (a ^ 32'h1300_0013);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Instruction memory: ack 'lat' cycles after a request is first seen.
  initial begin
    int cnt;
    cnt = 0;
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        bus.imem_ack = 1'b0;
        cnt = 0;
      end else if (bus.imem_ack) begin
        bus.imem_ack = 1'b0;
        cnt = 0;
      end else if (bus.imem_req) begin
        if (cnt == lat) begin
          bus.imem_ack   = 1'b1;
          bus.imem_rdata = mem_word(bus.imem_addr);
        end else begin
          cnt++;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // Monitor: new fetch requests and accepted instructions against the queues.
  initial begin
    logic req_prev, ack_prev;
    logic [31:0] ea;
    acc_t e;
    req_prev = 1'b0;
    ack_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (bus.imem_req && (!req_prev || ack_prev)) begin
          if (exp_req.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL req_addr: got unexpected request %h expected none", bus.imem_addr);
          end else begin
            ea = exp_req.pop_front();
            check("req_addr", bus.imem_addr, ea);
          end
        end
        if (bus.if_valid && bus.if_ready && !br_taken && !jmp_taken) begin
          if (exp_acc.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL accept: got unexpected pc %h expected none", bus.if_pc);
          end else begin
            e = exp_acc.pop_front();
            check("acc_pc", bus.if_pc, e.pc);
            check("acc_instr", bus.if_instr, e.instr);
            check("acc_pc4", bus.if_pc4, e.pc + 32'd4);
          end
        end
      end
      req_prev = bus.imem_req;
      ack_prev = bus.imem_ack;
    end
  end

  task automatic push_acc(input logic [31:0] pc);
    acc_t e;
    e.pc    = pc;
    e.instr = mem_word(pc);
    exp_acc.push_back(e);
  endtask

  task automatic wait_valid(input int max);
    int n;
    n = 0;
    while (!bus.if_valid && n < max) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("wait_valid", {31'd0, bus.if_valid}, 32'd1);
  endtask

  task automatic pulse_ready();
    @(posedge clk);
    #1 bus.if_ready = 1'b1;
    @(posedge clk);
    #1 bus.if_ready = 1'b0;
  endtask

  task automatic redirect(input logic j, input logic [31:0] jt,
                          input logic b, input logic [31:0] bb, input logic [31:0] bo);
    jmp_taken  = j;
    jmp_target = jt;
    br_taken   = b;
    br_base    = bb;
    br_offset  = bo;
    @(posedge clk);
    #1;
    jmp_taken = 1'b0;
    br_taken  = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_req"},   {31'd0, bus.imem_req}, 32'd0);
    check({tag, "_addr"},  bus.imem_addr, 32'h0);
    check({tag, "_valid"}, {31'd0, bus.if_valid}, 32'd0);
    check({tag, "_instr"}, bus.if_instr, 32'h0);
    check({tag, "_pc"},    bus.if_pc, 32'h0);
    check({tag, "_pc4"},   bus.if_pc4, 32'h0);
`ifdef MISALIGN_TRAP_EN
    check({tag, "_misalign"}, {31'd0, misalign_err}, 32'd0);
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    rst_n       = 1'b0;
    br_taken    = 1'b0;
    br_base     = '0;
    br_offset   = '0;
    jmp_taken   = 1'b0;
    jmp_target  = '0;
    bus.if_ready = 1'b1;

    #20;
    check_reset_state("rst");

    // Sequential fetch 0x0, 0x4, 0x8 with backpressure on the 0x4 word.
    exp_req.push_back(32'h0);
    exp_req.push_back(32'h4);
    exp_req.push_back(32'h8);
    push_acc(32'h0);
    push_acc(32'h4);
    @(posedge clk);
    #1 rst_n = 1'b1;
    n = 0;
    while (!bus.if_valid && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("first_valid_lat", n, 3);
    @(posedge clk);
    #1 bus.if_ready = 1'b0;
    wait_valid(10);
    repeat (5) begin
      @(posedge clk);
      #1;
      check("bp_valid", {31'd0, bus.if_valid}, 32'd1);
      check("bp_req",   {31'd0, bus.imem_req}, 32'd0);
      check("bp_instr", bus.if_instr, 32'h8C22_0004);
      check("bp_pc",    bus.if_pc, 32'h4);
      check("bp_pc4",   bus.if_pc4, 32'h8);
    end
    bus.if_ready = 1'b1;
    @(posedge clk);
    #1 bus.if_ready = 1'b0;
    wait_valid(10);

    // Branch in VALID flushes the parked 0x8 word.
    exp_req.push_back(32'hF0);
    redirect(1'b0, 32'h0, 1'b1, 32'h100, 32'hFFFF_FFF0);
    check("brv_valid", {31'd0, bus.if_valid}, 32'd0);
    check("brv_addr",  bus.imem_addr, 32'hF0);
    wait_valid(10);
    check("brv_pc", bus.if_pc, 32'hF0);

    // Branch while the 0x40 fetch is outstanding: its word must be dropped.
    lat = 3;
    exp_req.push_back(32'h40);
    exp_req.push_back(32'h210);
    redirect(1'b1, 32'h40, 1'b0, 32'h0, 32'h0);
    @(posedge clk);
    #1;
    br_taken  = 1'b1;
    br_base   = 32'h200;
    br_offset = 32'h10;
    @(posedge clk);
    #1 br_taken = 1'b0;
    check("kill_addr_held", bus.imem_addr, 32'h40);
    check("kill_req_held",  {31'd0, bus.imem_req}, 32'd1);
    wait_valid(30);
    check("kill_pc", bus.if_pc, 32'h210);
    push_acc(32'h210);
    exp_req.push_back(32'h214);
    pulse_ready();
    wait_valid(30);

    // Simultaneous jump and branch: jump wins.
    lat = 1;
    exp_req.push_back(32'h2000);
    redirect(1'b1, 32'h2000, 1'b1, 32'h300, 32'h0);
    wait_valid(10);
    check("prio_pc", bus.if_pc, 32'h2000);
    push_acc(32'h2000);
    exp_req.push_back(32'h2004);
    pulse_ready();
    wait_valid(10);

    // Branch target wraps modulo 2^32.
    exp_req.push_back(32'h8);
    redirect(1'b0, 32'h0, 1'b1, 32'hFFFF_FFF8, 32'h10);
    wait_valid(10);
    check("wrap_br_pc", bus.if_pc, 32'h8);
    push_acc(32'h8);
    exp_req.push_back(32'hC);
    pulse_ready();
    wait_valid(10);

    // pc + 4 wraps from the top of the address space.
    exp_req.push_back(32'hFFFF_FFFC);
    redirect(1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 32'h0);
    wait_valid(10);
    check("top_pc4", bus.if_pc4, 32'h0);
    push_acc(32'hFFFF_FFFC);
    exp_req.push_back(32'h0);
    pulse_ready();
    wait_valid(10);

    // Redirect in the same cycle as ack.
    exp_req.push_back(32'h600);
    exp_req.push_back(32'h700);
    redirect(1'b1, 32'h600, 1'b0, 32'h0, 32'h0);
    @(posedge clk);
    #1;
    br_taken  = 1'b1;
    br_base   = 32'h700;
    br_offset = 32'h0;
    @(posedge clk);
    #1 br_taken = 1'b0;
    wait_valid(10);
    check("ackredir_pc", bus.if_pc, 32'h700);

    // Misaligned jump target.
`ifdef MISALIGN_TRAP_EN
    exp_req.push_back(32'h80);
    redirect(1'b1, 32'h1002, 1'b0, 32'h0, 32'h0);
    check("misalign_hi", {31'd0, misalign_err}, 32'd1);
    @(posedge clk);
    #1 check("misalign_lo", {31'd0, misalign_err}, 32'd0);
    wait_valid(10);
    check("trap_pc", bus.if_pc, 32'h80);
`else
    exp_req.push_back(32'h1002);
    redirect(1'b1, 32'h1002, 1'b0, 32'h0, 32'h0);
    wait_valid(10);
    check("unaligned_pc", bus.if_pc, 32'h1002);
`endif

    // Reset asserted mid-fetch, then a jump while IDLE.
    lat = 3;
    exp_req.push_back(32'h900);
    redirect(1'b1, 32'h900, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_state("midrst");
    lat = 1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1 rst_n = 1'b1;
    exp_req.push_back(32'h500);
    redirect(1'b1, 32'h500, 1'b0, 32'h0, 32'h0);
    wait_valid(10);
    check("idle_jmp_pc", bus.if_pc, 32'h500);
    push_acc(32'h500);
    exp_req.push_back(32'h504);
    pulse_ready();
    wait_valid(10);

    repeat (3) @(posedge clk);
    #1;
    check("req_queue_drained", exp_req.size(), 32'd0);
    check("acc_queue_drained", exp_acc.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
